// File: rtl/keypad_pkg.sv
// Shared types and the 4x3 key map for the keypad scanner.
// Column index 0 is the leftmost key of a row and arrives on col_n[2].
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Rows 0..2 are 1-2-3 / 4-5-6 / 7-8-9; row 3 is * 0 #.
  function automatic logic [3:0] code_of(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Parametrized-width two-flop synchronizer for asynchronous inputs.
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: row drive, column debounce and one event per keystroke.
// Digits pulse pressed with key; '#' pulses set_code; '*' is swallowed.
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key,
  output logic       pressed,
  output logic       set_code
);

  import keypad_pkg::*;

  localparam int            DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int            CW       = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [2:0]    cs_n;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    row_q, row_d;
  state_t        state_q, state_d;
  logic [3:0]    code_q, code_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic [CW-1:0] rel_cnt_q, rel_cnt_d;
  logic [3:0]    key_q, key_d;
  logic          pressed_q, pressed_d;
  logic          set_code_q, set_code_d;

  logic          sample;
  logic          sample_valid;
  logic [1:0]    sample_col;
  logic [3:0]    sample_code;
  logic          accept;

  sync2 #(
    .WIDTH     (3),
    .RESET_VAL (3'b111)
  ) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col_n),
    .q     (cs_n)
  );

  // Exactly one low column is a valid sample; anything else counts as none.
  always_comb begin
    sample_valid = 1'b1;
    sample_col   = 2'd0;
    case (cs_n)
      3'b011:  sample_col = 2'd0;
      3'b101:  sample_col = 2'd1;
      3'b110:  sample_col = 2'd2;
      default: sample_valid = 1'b0;
    endcase
  end

  assign sample      = (div_q == DIV_LAST);
  assign div_d       = sample ? '0 : div_q + DW'(1);
  assign sample_code = code_of(row_q, sample_col);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    code_d    = code_q;
    deb_cnt_d = deb_cnt_q;
    rel_cnt_d = rel_cnt_q;
    accept    = 1'b0;
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (!sample_valid) begin
            row_d = row_q + 2'd1;
          end else begin
            code_d    = sample_code;
            deb_cnt_d = CNT_ONE;
            if (CNT_LAST == CNT_ONE) begin
              accept    = 1'b1;
              state_d   = HELD;
              rel_cnt_d = '0;
            end else begin
              state_d = keypad_pkg::DEBOUNCE;
            end
          end
        end
        keypad_pkg::DEBOUNCE: begin
          if (!sample_valid) begin
            state_d = SCAN;
            row_d   = row_q + 2'd1;
          end else if (sample_code != code_q) begin
            code_d    = sample_code;
            deb_cnt_d = CNT_ONE;
          end else if (deb_cnt_q + CNT_ONE == CNT_LAST) begin
            accept    = 1'b1;
            state_d   = HELD;
            deb_cnt_d = CNT_LAST;
            rel_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (sample_valid) begin
            rel_cnt_d = '0;
          end else if (rel_cnt_q + CNT_ONE == CNT_LAST) begin
            state_d   = SCAN;
            row_d     = row_q + 2'd1;
            rel_cnt_d = '0;
          end else begin
            rel_cnt_d = rel_cnt_q + CNT_ONE;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Events are registered so they appear in the cycle after acceptance.
  always_comb begin
    key_d      = key_q;
    pressed_d  = 1'b0;
    set_code_d = 1'b0;
    if (accept) begin
      if (sample_code == KEY_HASH) begin
        set_code_d = 1'b1;
      end else if (sample_code != KEY_STAR) begin
        pressed_d = 1'b1;
        key_d     = sample_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      row_q      <= 2'd0;
      state_q    <= SCAN;
      code_q     <= 4'd0;
      deb_cnt_q  <= '0;
      rel_cnt_q  <= '0;
      key_q      <= 4'd0;
      pressed_q  <= 1'b0;
      set_code_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      row_q      <= row_d;
      state_q    <= state_d;
      code_q     <= code_d;
      deb_cnt_q  <= deb_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      key_q      <= key_d;
      pressed_q  <= pressed_d;
      set_code_q <= set_code_d;
    end
  end

  assign row_n    = ~(4'b0001 << row_q);
  assign key      = key_q;
  assign pressed  = pressed_q;
  assign set_code = set_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x3 key matrix.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key;
  logic       pressed;
  logic       set_code;

  logic       force_en;
  logic [2:0] force_val;
  logic       hold_en;
  int         hold_row;
  int         hold_col;

  int         errors = 0;
  int         checks = 0;
  int         press_cnt = 0;
  int         set_cnt = 0;
  logic [3:0] key_log[$];

  int         prev_pulse = 0;
  int         seen_pulse = 0;
  int         gap = 0;

  int seq_row [9] = '{0, 0, 0, 1, 3, 0, 0, 0, 1};
  int seq_col [9] = '{0, 1, 2, 0, 2, 0, 1, 2, 0};
  int exp_key [8] = '{1, 2, 3, 4, 1, 2, 3, 4};

  keypad_scanner #(
    .SCAN_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_n    (col_n),
    .row_n    (row_n),
    .key      (key),
    .pressed  (pressed),
    .set_code (set_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The held key pulls its column low only while its row is driven.
  always @* begin
    if (force_en) begin
      col_n = force_val;
    end else begin
      col_n = 3'b111;
      if (hold_en && row_n[hold_row] == 1'b0) col_n[2 - hold_col] = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int r, input int c, input int hold, input int gap_cycles);
    hold_row = r;
    hold_col = c;
    hold_en  = 1'b1;
    waitCycles(hold);
    hold_en  = 1'b0;
    waitCycles(gap_cycles);
  endtask

  // Event monitor: exclusivity, single-cycle width and minimum spacing of pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pulse = 0;
      seen_pulse = 0;
      gap        = 0;
    end else begin
      if (pressed || set_code) begin
        checkOutput("pulse_exclusive", 32'(pressed & set_code), 32'd0);
        checkOutput("pulse_width", 32'(prev_pulse), 32'd0);
        if (seen_pulse != 0) checkOutput("pulse_gap", 32'(gap >= 12), 32'd1);
        seen_pulse = 1;
        gap        = 0;
        if (pressed) begin
          press_cnt++;
          key_log.push_back(key);
        end
        if (set_code) set_cnt++;
      end else begin
        gap++;
      end
      prev_pulse = (pressed || set_code) ? 1 : 0;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int first;
    int base_p;
    int base_s;
    int base_k;
    int found;
    int changes;
    int bounce_pulses;
    logic [3:0] prev_row;

    rst_n     = 1'b1;
    force_en  = 1'b1;
    force_val = 3'b011;
    hold_en   = 1'b0;
    hold_row  = 0;
    hold_col  = 0;
    #2 rst_n  = 1'b0;

    // Reset with '1' already held; first sample is cycle 3, pulse 9 cycles later.
    waitCycles(3);
    checkOutput("rst_row_n", 32'(row_n), 32'(4'b1110));
    checkOutput("rst_key", 32'(key), 32'd0);
    checkOutput("rst_pressed", 32'(pressed), 32'd0);
    checkOutput("rst_set_code", 32'(set_code), 32'd0);
    rst_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (pressed && first == 0) first = i;
    end
    checkOutput("rst_latency", 32'(first), 32'd12);
    checkOutput("rst_key1", 32'(key), 32'd1);
    checkOutput("rst_press_count", 32'(press_cnt), 32'd1);
    force_en = 1'b0;
    waitCycles(30);

    // Clean '5' with the row frozen while held and shortly after release.
    base_p   = press_cnt;
    hold_row = 1;
    hold_col = 1;
    hold_en  = 1'b1;
    waitCycles(40);
    checkOutput("five_row_held", 32'(row_n), 32'(4'b1101));
    hold_en = 1'b0;
    waitCycles(4);
    checkOutput("five_row_release", 32'(row_n), 32'(4'b1101));
    waitCycles(26);
    checkOutput("five_count", 32'(press_cnt - base_p), 32'd1);
    checkOutput("five_key", 32'(key), 32'd5);

    // '#' pulses set_code only; key keeps the 5.
    base_p = press_cnt;
    base_s = set_cnt;
    applyStimulus(3, 2, 30, 30);
    checkOutput("hash_set_count", 32'(set_cnt - base_s), 32'd1);
    checkOutput("hash_press_count", 32'(press_cnt - base_p), 32'd0);
    checkOutput("hash_key_kept", 32'(key), 32'd5);

    // Bounce on '0': start two cycles into a row-3 dwell so sampled phases read open.
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (row_n == 4'b0111) found = 1;
    end
    checkOutput("bounce_row3_found", 32'(found), 32'd1);
    base_p   = press_cnt;
    hold_row = 3;
    hold_col = 1;
    waitCycles(2);
    bounce_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) hold_en = ~hold_en;
      @(negedge clk);
      if (pressed || set_code) bounce_pulses++;
    end
    checkOutput("bounce_quiet", 32'(bounce_pulses), 32'd0);
    applyStimulus(3, 1, 30, 30);
    checkOutput("bounce_count", 32'(press_cnt - base_p), 32'd1);
    checkOutput("bounce_key", 32'(key), 32'd0);

    // Two columns low: treated as none, so rows keep advancing every dwell.
    base_p    = press_cnt;
    base_s    = set_cnt;
    force_val = 3'b100;
    force_en  = 1'b1;
    prev_row  = row_n;
    changes   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (row_n != prev_row) changes++;
      prev_row = row_n;
    end
    force_en = 1'b0;
    waitCycles(10);
    checkOutput("double_row_steps", 32'(changes), 32'd5);
    checkOutput("double_no_event", 32'(press_cnt - base_p + set_cnt - base_s), 32'd0);

    // '*' is reserved and produces nothing.
    base_p = press_cnt;
    base_s = set_cnt;
    applyStimulus(3, 0, 30, 30);
    checkOutput("star_no_press", 32'(press_cnt - base_p), 32'd0);
    checkOutput("star_no_set", 32'(set_cnt - base_s), 32'd0);
    checkOutput("star_key_kept", 32'(key), 32'd0);

    // Sequence 1,2,3,4,#,1,2,3,4.
    base_p = press_cnt;
    base_s = set_cnt;
    base_k = key_log.size();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(seq_row[i], seq_col[i], 30, 30);
      if (i == 3) checkOutput("seq_no_set_yet", 32'(set_cnt - base_s), 32'd0);
      if (i == 4) checkOutput("seq_set_between", 32'(set_cnt - base_s), 32'd1);
    end
    checkOutput("seq_press_count", 32'(press_cnt - base_p), 32'd8);
    checkOutput("seq_set_count", 32'(set_cnt - base_s), 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("seq_key%0d", i), 32'(key_log[base_k + i]), 32'(exp_key[i]));
    end

    // Reset in the middle of debouncing '9' must abort it.
    base_p   = press_cnt;
    hold_row = 2;
    hold_col = 2;
    hold_en  = 1'b1;
    found    = 0;
    for (int i = 0; i < 24 && found == 0; i++) begin
      @(negedge clk);
      if (row_n == 4'b1011) found = 1;
    end
    checkOutput("mid_row2_found", 32'(found), 32'd1);
    waitCycles(6);
    checkOutput("mid_not_yet", 32'(press_cnt - base_p), 32'd0);
    rst_n   = 1'b0;
    hold_en = 1'b0;
    waitCycles(2);
    checkOutput("mid_rst_row_n", 32'(row_n), 32'(4'b1110));
    checkOutput("mid_rst_key", 32'(key), 32'd0);
    checkOutput("mid_rst_pressed", 32'(pressed), 32'd0);
    base_p = press_cnt;
    base_s = set_cnt;
    rst_n  = 1'b1;
    waitCycles(40);
    checkOutput("mid_no_press", 32'(press_cnt - base_p), 32'd0);
    checkOutput("mid_no_set", 32'(set_cnt - base_s), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Front-end stage directly upstream of the keypad digit register and the lock.
- Scans a 4x3 membrane keypad matrix, synchronizes and debounces the column returns, and decodes the key.
- Emits exactly one single-cycle event per physical keystroke: a digit on key/pressed, or '#' on set_code.
- Its outputs drive the key, pressed and set_code inputs of the lock directly.

Parameters:
- SCAN_DIV, 4: clock cycles each row is driven before its columns are sampled (dwell length, >=2).
- DEBOUNCE, 3: consecutive identical dwell samples required to accept a press or a release (>=1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- col_n  input  3  raw matrix column returns, active-low, asynchronous to clk.
- row_n  output  4  matrix row drive, one-hot active-low.
- key  output  4  decoded digit 0..9; holds its last value between events.
- pressed  output  1  one-cycle pulse: key is valid this cycle.
- set_code  output  1  one-cycle pulse: '#' accepted.

Behaviour:
- Reset values: row_n=4'b1110 (row 0), key=0, pressed=0, set_code=0, FSM=SCAN, counters=0.
- Reset mid-operation aborts any debounce or hold immediately. No pulse may follow the reset release until a new full debounce completes.
- col_n passes through a 2-flop synchronizer. All decisions use the synchronized value cs_n.
- Dwell counter counts 0..SCAN_DIV-1 and wraps. A sample is taken in the cycle the counter equals SCAN_DIV-1.
- Key map (row, col):
  - row0 = 1 2 3
  - row1 = 4 5 6
  - row2 = 7 8 9
  - row3 = * 0 #
- Internal code: 0..9 for digits, 10 for '*', 11 for '#'.
- A sample is "none" when cs_n==3'b111. It is "invalid" when more than one column is low. Invalid is treated as none.
- FSM states:
  - SCAN: at each sample, if none, advance row_n to the next row (3 wraps to 0). Otherwise latch the candidate code, set deb_cnt=1 and go to DEBOUNCE. The row stays frozen.
  - DEBOUNCE: at each sample, if same code, deb_cnt++; if a different valid code, relatch it and set deb_cnt=1. If none, go to SCAN and advance to the next row.
  - DEBOUNCE acceptance: when deb_cnt reaches DEBOUNCE (immediately if DEBOUNCE=1), go to HELD and raise the accept event in the following cycle.
  - HELD: the row stays frozen. Each none sample does rel_cnt++; any valid sample sets rel_cnt=0. When rel_cnt reaches DEBOUNCE, go to SCAN and advance to the next row.
- Accept event:
  - Digit: key<=code and pressed=1 for exactly one cycle.
  - '#': set_code=1 for exactly one cycle; key is unchanged.
  - '*': no output (reserved).
- pressed and set_code are never high in the same cycle. Each pulse is followed by at least DEBOUNCE*SCAN_DIV cycles low.
- Holding a key produces exactly one event, with no auto-repeat.
- While in HELD, presses on other rows are invisible. After release, scanning resumes.
- Accept latency from the first sampled press: (DEBOUNCE-1)*SCAN_DIV+1 cycles. From a col_n edge, add up to SCAN_DIV+2 cycles (synchronizer plus sample alignment).
- Bounce shorter than one dwell can at most restart the debounce. It never produces a double event.

Decomposition:
- Package keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, HELD}
  - constants KEY_STAR=4'd10 and KEY_HASH=4'd11
  - the 4x3 decode table as a constant function code_of(row, col)
- One sub-module: sync2 (parametrized-width 2-flop synchronizer) for col_n.

Test Plan (SCAN_DIV=4, DEBOUNCE=3):
- Reset: hold rst_n=0 while col_n=3'b011 -> row_n=4'b1110, key=0, pressed=0, set_code=0. After release, exactly one pressed with key=1 arrives, no earlier than 9 cycles after the first sample.
- Clean '5': col_n[1] low while row1 is driven, held 40 cycles then released -> a single pressed pulse with key=5; row_n frozen at 4'b1101 until 3 none samples are seen.
- '#': row3/col2 held 30 cycles -> set_code=1 for one cycle; pressed stays 0; key retains its previous digit.
- Bounce: '0' toggles every 2 cycles for 12 cycles, then is stable -> exactly one pressed with key=0, with no pulse during the bounce.
- Double column: row0 samples 3'b100 (two columns low) -> no event and scanning continues; '*' held -> no event at all.
- Sequence 1,2,3,4,#,1,2,3,4 with 30-cycle holds and 30-cycle gaps -> eight pressed pulses carrying 1,2,3,4,1,2,3,4 in order, plus one set_code between them.
